// File: rtl/mux_scan_sequencer_if.sv
// Handshake/data bundle between a scan controller and mux_scan_sequencer.
// Start,f: controller->sequencer; S16,Capture,Busy,Done(,Parity): back.
interface mux_scan_sequencer_if;
  logic        Start;
  logic        f;
  logic [3:0]  S16;
  logic [0:15] Capture;
  logic        Busy;
  logic        Done;
`ifdef SCAN_PARITY_EN
  logic        Parity;

  modport master (
    output Start,
    output f,
    input  S16,
    input  Capture,
    input  Busy,
    input  Done,
    input  Parity
  );

  modport slave (
    input  Start,
    input  f,
    output S16,
    output Capture,
    output Busy,
    output Done,
    output Parity
  );
`else
  modport master (
    output Start,
    output f,
    input  S16,
    input  Capture,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  f,
    output S16,
    output Capture,
    output Busy,
    output Done
  );
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a mux16to1 select through 0..15, samples f per code into Capture.
// Ports: Clock, Resetn (async low), bus (slave). Option: SCAN_PARITY_EN.
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  mux_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  generate
    if (DWELL < 1 || DWELL >= (2 ** CNT_W)) begin : g_bad_cfg
      initial begin
        $display("mux_scan_sequencer: illegal DWELL=%0d CNT_W=%0d",
                 DWELL, CNT_W);
        $finish;
      end
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         s16;
  logic [0:15]        capture;
  logic               busy;
  logic               done;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      s16     <= 4'd0;
      capture <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            state <= SETTLE;
            s16   <= 4'd0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST)
            state <= SAMPLE;
        end
        SAMPLE: begin
          capture[s16] <= bus.f;
          if (s16 != 4'd15) begin
            s16   <= s16 + 4'd1;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          s16   <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity;

  // Capture is complete once in FINISH, so the fold is taken there.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      parity <= 1'b0;
    else if (state == FINISH)
      parity <= ^capture;
  end

  assign bus.Parity = parity;
`endif

  assign bus.S16     = s16;
  assign bus.Capture = capture;
  assign bus.Busy    = busy;
  assign bus.Done    = done;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with an inline mux16to1 model.
// Checks scan timing, capture, ignored Start, async reset, back-to-back.
module tb_mux_scan_sequencer;

  localparam int DWELL = 2;
  localparam int P     = DWELL + 1;
  localparam int LAST  = 16 * P;

  logic        clk;
  logic        rst_n;
  logic [0:15] w;
  int          n_checks;
  int          n_fail;

  mux_scan_sequencer_if bus ();

  mux_scan_sequencer #(
    .DWELL (DWELL),
    .CNT_W (4)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  assign bus.f = w[bus.S16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic hold);
    @(negedge clk);
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.S16 !== 4'd0 || bus.Capture !== 16'h0 ||
        bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got s16=%0d cap=%h busy=%b done=%b exp 0",
               bus.S16, bus.Capture, bus.Busy, bus.Done);
    end
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.S16 !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_no_start got busy=%b done=%b s16=%0d exp 0/0/0",
               bus.Busy, bus.Done, bus.S16);
    end
  endtask

  task automatic test_pattern();
    int done_at;
    int done_n;
    logic [3:0] exp_s16;
    logic exp_busy;
    logic exp_done;
    done_at = -1;
    done_n  = 0;
    w = 16'b0101010101010101;
    start_scan(1'b0);
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) tick();
      exp_s16  = (k < LAST) ? 4'(k / P) : ((k == LAST) ? 4'd15 : 4'd0);
      exp_busy = (k < LAST);
      exp_done = (k == LAST + 1);
      n_checks++;
      if (bus.S16 !== exp_s16) begin
        n_fail++;
        $display("FAIL s16_seq k=%0d got %0d exp %0d", k, bus.S16, exp_s16);
      end
      n_checks++;
      if (bus.Busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy_seq k=%0d got %b exp %b", k, bus.Busy, exp_busy);
      end
      n_checks++;
      if (bus.Done !== exp_done) begin
        n_fail++;
        $display("FAIL done_seq k=%0d got %b exp %b", k, bus.Done, exp_done);
      end
      if (bus.Done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k == LAST + 1) begin
        n_checks++;
        if (bus.Capture !== 16'b0101010101010101) begin
          n_fail++;
          $display("FAIL capture_5555 got %h exp 5555", bus.Capture);
        end
      end
    end
    n_checks++;
    if (done_at !== 49 || done_n !== 1) begin
      n_fail++;
      $display("FAIL done_latency got at=%0d n=%0d exp at=49 n=1",
               done_at, done_n);
    end
  endtask

  task automatic test_start_ignored();
    int done_n;
    int done_at;
    done_n  = 0;
    done_at = -1;
    w = 16'h3C5A;
    start_scan(1'b0);
    for (int k = 1; k <= 120; k++) begin
      tick();
      // Start is seen at the edge ending cycle 23, when S16 is 7.
      bus.Start = (k == 22);
      if (k == 22) begin
        n_checks++;
        if (bus.S16 !== 4'd7) begin
          n_fail++;
          $display("FAIL mid_s16 got %0d exp 7", bus.S16);
        end
      end
      if (k < LAST) begin
        n_checks++;
        if (bus.Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_held k=%0d got %b exp 1", k, bus.Busy);
        end
      end
      if (k > LAST) begin
        n_checks++;
        if (bus.Busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_idle k=%0d got %b exp 0", k, bus.Busy);
        end
      end
      if (bus.Done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    bus.Start = 1'b0;
    n_checks++;
    if (done_n !== 1 || done_at !== 49) begin
      n_fail++;
      $display("FAIL ignore_start got n=%0d at=%0d exp n=1 at=49",
               done_n, done_at);
    end
    n_checks++;
    if (bus.Capture !== 16'h3C5A) begin
      n_fail++;
      $display("FAIL capture_3c5a got %h exp 3c5a", bus.Capture);
    end
  endtask

  task automatic test_async_reset();
    int done_at;
    done_at = -1;
    w = 16'hA5A5;
    start_scan(1'b0);
    for (int k = 1; k <= 27; k++) tick();
    n_checks++;
    if (bus.S16 !== 4'd9) begin
      n_fail++;
      $display("FAIL pre_reset_s16 got %0d exp 9", bus.S16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.S16 !== 4'd0 || bus.Capture !== 16'h0 ||
        bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got s16=%0d cap=%h busy=%b done=%b exp 0",
               bus.S16, bus.Capture, bus.Busy, bus.Done);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    w = 16'hFFFF;
    start_scan(1'b0);
    for (int k = 1; k <= 55; k++) begin
      tick();
      if (bus.Done === 1'b1 && done_at < 0) done_at = k;
    end
    n_checks++;
    if (done_at !== 49) begin
      n_fail++;
      $display("FAIL rescan_done got %0d exp 49", done_at);
    end
    n_checks++;
    if (bus.Capture !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL capture_ffff got %h exp ffff", bus.Capture);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    w = 16'h8001;
    start_scan(1'b1);
    for (int k = 1; k <= 170; k++) begin
      tick();
      if (k == 50) begin
        n_checks++;
        if (bus.Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart got busy=%b exp 1", bus.Busy);
        end
      end
      if (bus.Done === 1'b1) begin
        n_checks++;
        if (k !== 49 + 50 * n) begin
          n_fail++;
          $display("FAIL b2b_period got k=%0d exp %0d", k, 49 + 50 * n);
        end
        n_checks++;
        if (bus.Capture !== 16'h8001) begin
          n_fail++;
          $display("FAIL b2b_capture got %h exp 8001", bus.Capture);
        end
        n++;
        if (n == 3) bus.Start = 1'b0;
      end
    end
    bus.Start = 1'b0;
    n_checks++;
    if (n !== 3 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count got n=%0d busy=%b exp n=3 busy=0",
               n, bus.Busy);
    end
  endtask

`ifdef SCAN_PARITY_EN
  task automatic test_parity();
    logic [0:15] pats [2];
    logic        exps [2];
    logic        got;
    pats[0] = 16'h0007;
    exps[0] = 1'b1;
    pats[1] = 16'h0003;
    exps[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = 1'bx;
      w = pats[i];
      start_scan(1'b0);
      for (int k = 1; k <= 55; k++) begin
        tick();
        if (bus.Done === 1'b1) got = bus.Parity;
      end
      n_checks++;
      if (got !== exps[i]) begin
        n_fail++;
        $display("FAIL parity_%0d got %b exp %b", i, got, exps[i]);
      end
      n_checks++;
      if (bus.Parity !== exps[i]) begin
        n_fail++;
        $display("FAIL parity_hold_%0d got %b exp %b",
                 i, bus.Parity, exps[i]);
      end
    end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    w         = '0;
    test_reset();
    test_pattern();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
`ifdef SCAN_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
